// File: rtl/fifo_ku_stream_pkg.sv
// Shared types and header-layout constants for the KU FIFO stream reader family.
package fifo_ku_stream_pkg;

  typedef enum logic [0:0] {
    HEAD = 1'b0,
    DATA = 1'b1
  } stream_rd_state_e;

  localparam int          DEF_LEN_BITS = 16;
  localparam int          HDR_LEN_LSB  = 0;
  localparam int          HDR_TAG_LSB  = DEF_LEN_BITS;
  localparam logic [15:0] DEF_MAGIC    = 16'hA55A;

endpackage

// File: rtl/fifo_ku_skid2.sv
// Generic 2-entry valid/ready skid buffer; entry 0 is the head that drives the output.
module fifo_ku_skid2 #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  // Handshake: a beat transfers on a side exactly when valid & ready are both high
  // at the clock edge; in_ready depends only on registered occupancy.
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   occ;
  logic         push;
  logic         pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = ent0;
  assign occupancy = occ;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= in_data;
          else             ent1 <= in_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= in_data;
          end else begin
            ent0 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_ku_stream_reader.sv
// Drains a FWFT FIFO and frames its words into a valid/ready stream using length headers.
// Optional header tag check: define FIFO_KU_STREAM_READER_MAGIC_CHK_EN.
module fifo_ku_stream_reader
  import fifo_ku_stream_pkg::*;
#(
  parameter int          DSIZE    = 36,
  parameter int          LEN_BITS = 16,
  parameter logic [15:0] MAGIC    = DEF_MAGIC
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             pkt_done,
  output logic [15:0]      pkt_cnt,
  output logic             busy,
  output logic             err_hdr,
  output stream_rd_state_e state_dbg
);

  stream_rd_state_e    state;
  logic [LEN_BITS-1:0] remaining;
  logic [LEN_BITS-1:0] hdr_len;
  logic                buf_ready;
  logic [1:0]          buf_occ;
  logic                pop_head;
  logic                pop_data;
  logic                last_word;
  logic                tag_ok;
  logic                beat_last;

`ifdef FIFO_KU_STREAM_READER_MAGIC_CHK_EN
  assign tag_ok = (fifo_dout[LEN_BITS +: 16] == MAGIC);
`else
  assign tag_ok = 1'b1;
`endif

  // Pop decision sees only registered state/occupancy, never m_tready.
  assign fifo_rd_en = !rd_rst && !fifo_empty && ((state == HEAD) || buf_ready);
  assign pop_head   = fifo_rd_en && (state == HEAD);
  assign pop_data   = fifo_rd_en && (state == DATA);
  assign hdr_len    = fifo_dout[HDR_LEN_LSB +: LEN_BITS];
  assign last_word  = (remaining == LEN_BITS'(1));
  assign beat_last  = m_tvalid & m_tready & m_tlast;
  assign busy       = (state == DATA) || (buf_occ != 2'd0);
  assign state_dbg  = state;

  fifo_ku_skid2 #(.W(DSIZE + 1)) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .in_valid  (pop_data),
    .in_data   ({last_word, fifo_dout}),
    .in_ready  (buf_ready),
    .out_valid (m_tvalid),
    .out_data  ({m_tlast, m_tdata}),
    .out_ready (m_tready),
    .occupancy (buf_occ)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= HEAD;
      remaining <= '0;
      pkt_done  <= 1'b0;
      pkt_cnt   <= 16'd0;
      err_hdr   <= 1'b0;
    end else begin
      pkt_done <= beat_last;
      if (beat_last) pkt_cnt <= pkt_cnt + 16'd1;
      err_hdr <= pop_head && !tag_ok;
      // A rejected tag or zero length leaves the header consumed with no framing.
      if (pop_head && tag_ok && (hdr_len != '0)) begin
        remaining <= hdr_len;
        state     <= DATA;
      end
      if (pop_data) begin
        remaining <= remaining - LEN_BITS'(1);
        if (last_word) state <= HEAD;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ku_stream_reader.sv
// Directed bench for fifo_ku_stream_reader with a queue-based FWFT FIFO model and beat monitor.
module tb_fifo_ku_stream_reader;
  import fifo_ku_stream_pkg::*;

  localparam int DSIZE = 36;

  logic             clk = 1'b0;
  logic             rd_rst;
  logic [DSIZE-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic             pkt_done;
  logic [15:0]      pkt_cnt;
  logic             busy;
  logic             err_hdr;
  stream_rd_state_e state_dbg;

  fifo_ku_stream_reader #(.DSIZE(DSIZE), .LEN_BITS(16), .MAGIC(16'hA55A)) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt), .busy(busy),
    .err_hdr(err_hdr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // FIFO model: bit DSIZE marks payload words (bench-side knowledge only).
  logic [DSIZE:0] fifo_q[$];
  logic [DSIZE:0] rx_q[$];
  logic [DSIZE:0] exp_q[$];
  int             beat_cyc[$];
  int             pop_cyc[$];
  int             ready_mode;
  int             cyc;
  int             payload_pops, beats, max_ahead;
  int             pkt_done_seen, err_seen, stable_err, rden_empty_err;
  logic           hold_prev;
  logic [DSIZE:0] prev_word;
  int             tests_run = 0;
  int             tests_failed = 0;

  function automatic logic [DSIZE-1:0] hdr(input logic [15:0] tag, input logic [15:0] len);
    return {4'h0, tag, len};
  endfunction

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0][DSIZE-1:0];
  endtask

  task automatic push_hdr(input logic [15:0] tag, input logic [15:0] len);
    fifo_q.push_back({1'b0, hdr(tag, len)});
    refresh();
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo_q.push_back({1'b1, w});
    refresh();
  endtask

  task automatic clear_monitor();
    rx_q.delete(); exp_q.delete(); beat_cyc.delete(); pop_cyc.delete();
    payload_pops = 0; beats = 0; max_ahead = 0; pkt_done_seen = 0;
    err_seen = 0; stable_err = 0; rden_empty_err = 0; hold_prev = 1'b0;
  endtask

  // One clock: sample at negedge, apply FIFO pop and next ready value #1 after the edge.
  task automatic tick();
    logic popped;
    @(negedge clk);
    if (fifo_rd_en && fifo_empty) rden_empty_err++;
    popped = fifo_rd_en && !fifo_empty;
    if (popped && fifo_q[0][DSIZE]) pop_cyc.push_back(cyc);
    if (hold_prev && (!m_tvalid || ({m_tlast, m_tdata} !== prev_word))) stable_err++;
    hold_prev = m_tvalid && !m_tready;
    prev_word = {m_tlast, m_tdata};
    if (m_tvalid && m_tready) begin
      rx_q.push_back({m_tlast, m_tdata});
      beat_cyc.push_back(cyc);
      beats++;
    end
    if (pkt_done) pkt_done_seen++;
    if (err_hdr) err_seen++;
    @(posedge clk);
    #1;
    if (popped) begin
      if (fifo_q[0][DSIZE]) payload_pops++;
      void'(fifo_q.pop_front());
    end
    if (payload_pops - beats > max_ahead) max_ahead = payload_pops - beats;
    if (ready_mode == 1)      m_tready = !m_tready;
    else if (ready_mode == 0) m_tready = 1'b1;
    else                      m_tready = 1'b0;
    refresh();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    fifo_q.delete();
    refresh();
    tick();
    rd_rst = 1'b0;
    clear_monitor();
  endtask

  task automatic test_reset();
    rd_rst = 1'b1;
    push_hdr(16'hA55A, 16'd3);
    tick();
    tick();
    tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    tests_run++; if (m_tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
    tests_run++; if (m_tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    tests_run++; if (pkt_done !== 1'b0) begin tests_failed++; $display("FAIL reset_pkt_done got %b want 0", pkt_done); end
    tests_run++; if (pkt_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (err_hdr !== 1'b0) begin tests_failed++; $display("FAIL reset_err_hdr got %b want 0", err_hdr); end
    tests_run++; if (state_dbg !== HEAD) begin tests_failed++; $display("FAIL reset_state got %0d want HEAD", state_dbg); end
    fifo_q.delete();
    refresh();
    rd_rst = 1'b0;
    clear_monitor();
  endtask

  task automatic test_basic();
    do_reset();
    ready_mode = 0;
    push_hdr(16'hA55A, 16'd3);
    push_word(36'h1); push_word(36'h2); push_word(36'h3);
    exp_q = '{{1'b0, 36'h1}, {1'b0, 36'h2}, {1'b1, 36'h3}};
    run(10);
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL basic_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests_run++;
      if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL basic_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    tests_run++;
    if (beat_cyc.size() != 3 || beat_cyc[2] - beat_cyc[0] != 2) begin tests_failed++; $display("FAIL basic_consecutive got %0d beats want 3 in 3 cycles", beat_cyc.size()); end
    tests_run++;
    if (pop_cyc.size() == 0 || beat_cyc.size() == 0 || beat_cyc[0] != pop_cyc[0] + 1) begin tests_failed++; $display("FAIL basic_latency got pops %0d beats %0d want beat one cycle after pop", pop_cyc.size(), beat_cyc.size()); end
    tests_run++; if (pkt_done_seen != 1) begin tests_failed++; $display("FAIL basic_pkt_done got %0d want 1", pkt_done_seen); end
    tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL basic_pkt_cnt got %0d want 1", pkt_cnt); end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_tvalid got %b want 0", m_tvalid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1;
    push_hdr(16'hA55A, 16'd3);
    push_word(36'h1); push_word(36'h2); push_word(36'h3);
    exp_q = '{{1'b0, 36'h1}, {1'b0, 36'h2}, {1'b1, 36'h3}};
    run(16);
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL bp_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests_run++;
      if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL bp_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    tests_run++; if (stable_err != 0) begin tests_failed++; $display("FAIL bp_stable got %0d changes want 0", stable_err); end
    tests_run++; if (max_ahead > 2) begin tests_failed++; $display("FAIL bp_ahead got %0d want <=2", max_ahead); end
    tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL bp_pkt_cnt got %0d want 1", pkt_cnt); end
    ready_mode = 0;
  endtask

  task automatic test_len_zero();
    do_reset();
    push_hdr(16'hA55A, 16'd0);
    push_hdr(16'hA55A, 16'd1);
    push_word(36'hAB);
    exp_q = '{{1'b1, 36'hAB}};
    run(8);
    tests_run++;
    if (rx_q.size() != 1) begin tests_failed++; $display("FAIL len0_count got %0d want 1", rx_q.size()); end
    else begin
      tests_run++;
      if (rx_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL len0_beat got %h want %h", rx_q[0], exp_q[0]); end
    end
    tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL len0_pkt_cnt got %0d want 1", pkt_cnt); end
    tests_run++; if (pkt_done_seen != 1) begin tests_failed++; $display("FAIL len0_pkt_done got %0d want 1", pkt_done_seen); end
  endtask

  task automatic test_empty_stall();
    do_reset();
    push_hdr(16'hA55A, 16'd4);
    push_word(36'h41); push_word(36'h42);
    exp_q = '{{1'b0, 36'h41}, {1'b0, 36'h42}, {1'b0, 36'h43}, {1'b1, 36'h44}};
    run(6);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL stall_busy%0d got %b want 1", i, busy); end
      tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL stall_rd_en%0d got %b want 0", i, fifo_rd_en); end
    end
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL stall_tvalid got %b want 0", m_tvalid); end
    push_word(36'h43); push_word(36'h44);
    run(8);
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL stall_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests_run++;
      if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stall_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    tests_run++; if (rden_empty_err != 0) begin tests_failed++; $display("FAIL stall_rd_en_empty got %0d want 0", rden_empty_err); end
    tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL stall_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_monitor();
    ready_mode = 2;
    m_tready = 1'b0;
    push_hdr(16'hA55A, 16'd4);
    push_word(36'h51);
    run(4);
    tests_run++; if (m_tvalid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_buffered got %b want 1", m_tvalid); end
    rd_rst = 1'b1;
    fifo_q.delete();
    refresh();
    tick();
    rd_rst = 1'b0;
    tests_run++; if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tvalid got %b want 0", m_tvalid); end
    tests_run++; if (pkt_cnt !== 16'd0) begin tests_failed++; $display("FAIL rstmid_pkt_cnt got %0d want 0", pkt_cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
    clear_monitor();
    ready_mode = 0;
    m_tready = 1'b1;
    push_hdr(16'hA55A, 16'd2);
    push_word(36'h61); push_word(36'h62);
    exp_q = '{{1'b0, 36'h61}, {1'b1, 36'h62}};
    run(8);
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rstmid_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests_run++;
      if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rstmid_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL rstmid_pkt_cnt_after got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_hdr(16'hA55A, 16'd2);
    push_word(36'h71); push_word(36'h72);
    push_hdr(16'hA55A, 16'd1);
    push_word(36'h73);
    exp_q = '{{1'b0, 36'h71}, {1'b1, 36'h72}, {1'b1, 36'h73}};
    run(12);
    tests_run++;
    if (rx_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      tests_run++;
      if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    tests_run++; if (pkt_cnt !== 16'd2) begin tests_failed++; $display("FAIL b2b_pkt_cnt got %0d want 2", pkt_cnt); end
    tests_run++; if (pkt_done_seen != 2) begin tests_failed++; $display("FAIL b2b_pkt_done got %0d want 2", pkt_done_seen); end
    tests_run++; if (err_seen != 0) begin tests_failed++; $display("FAIL b2b_err_hdr got %0d want 0", err_seen); end
  endtask

`ifdef FIFO_KU_STREAM_READER_MAGIC_CHK_EN
  task automatic test_magic();
    do_reset();
    push_hdr(16'h1234, 16'd5);
    push_hdr(16'hA55A, 16'd1);
    push_word(36'h5C);
    exp_q = '{{1'b1, 36'h5C}};
    run(8);
    tests_run++; if (err_seen != 1) begin tests_failed++; $display("FAIL magic_err_hdr got %0d want 1", err_seen); end
    tests_run++;
    if (rx_q.size() != 1) begin tests_failed++; $display("FAIL magic_count got %0d want 1", rx_q.size()); end
    else begin
      tests_run++;
      if (rx_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL magic_beat got %h want %h", rx_q[0], exp_q[0]); end
    end
    tests_run++; if (pkt_cnt !== 16'd1) begin tests_failed++; $display("FAIL magic_pkt_cnt got %0d want 1", pkt_cnt); end
  endtask
`endif

  initial begin
    rd_rst     = 1'b1;
    m_tready   = 1'b1;
    ready_mode = 0;
    cyc        = 0;
    clear_monitor();
    refresh();
    test_reset();
    test_basic();
    test_backpressure();
    test_len_zero();
    test_empty_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef FIFO_KU_STREAM_READER_MAGIC_CHK_EN
    test_magic();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_ku_stream_reader.md
Name: fifo_ku_stream_reader

Overview:
- Read-side companion to the FIFO36E2 first-word-fall-through wrapper.
- Drains the FIFO's read port (dout/empty/rd_en) and presents the data as a valid/ready stream master with packet framing.
- Framing comes from an in-band header word holding the payload length.
- Sits in the rd_clk domain directly after the FIFO. It registers its outputs so that m_tready never combinationally reaches fifo_rd_en.

Parameters:
- DSIZE, 36, FIFO word width; legal range 17..64 (header needs LEN_BITS+1 or more bits).
- LEN_BITS, 16, width of the payload-length field in header bits [LEN_BITS-1:0].
- MAGIC, 16'hA55A, expected header tag in bits [LEN_BITS+15:LEN_BITS]. Used only with the optional feature; DSIZE must be at least LEN_BITS+16 when the feature is enabled.

Ports:
- rd_clk  in  1  clock.
- rd_rst  in  1  synchronous reset, active-high.
- fifo_dout  in  DSIZE  FWFT head word; valid when fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop strobe; asserted only when fifo_empty=0.
- m_tdata  out  DSIZE  payload word.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last payload word of a packet.
- pkt_done  out  1  one-cycle pulse on handshake of the tlast word.
- pkt_cnt  out  16  completed-packet counter; wraps at 2^16.
- busy  out  1  high in state DATA or while the output buffer is non-empty.
- err_hdr  out  1  one-cycle pulse on header rejection (optional feature only; tied 0 otherwise).

Behaviour:
- Interface: one clock, rd_clk; reset rd_rst is synchronous and active-high.
- Reset values: fifo_rd_en=0, m_tvalid=0, m_tlast=0, m_tdata=0, pkt_done=0, pkt_cnt=0, busy=0, err_hdr=0. State=HEAD, output buffer empty, remaining=0.
- FSM states and transitions:
  - HEAD: when fifo_empty=0, pop one word as header; len = header[LEN_BITS-1:0].
  - len=0: header discarded, stay in HEAD, no output, pkt_cnt unchanged.
  - len>0: remaining=len, go to DATA.
  - DATA: pop a word whenever fifo_empty=0 and buffer occupancy <2 (occupancy sampled at the start of the cycle). Push the word into the buffer with last=(remaining==1), then decrement remaining. When the last word is popped, go to HEAD in the same cycle.
- Output buffer: 2-entry skid buffer; the head entry drives m_tdata, m_tvalid and m_tlast.
  - A push and a pop in the same cycle are legal.
  - m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0.
- Latency:
  - Word popped in cycle t appears on m_tdata in cycle t+1 when the buffer was empty.
  - Header pop to first payload pop is at least 1 cycle.
  - Sustained throughput is 1 word/cycle with m_tready=1 and the FIFO non-empty.
- fifo_rd_en is a function of fifo_empty, state and registered occupancy only; it never depends on m_tready.
- FIFO empty mid-packet: stall and hold remaining. No timeout; m_tvalid drops once the buffer drains.
- Header pop in HEAD does not wait on buffer space. The previous packet's buffered words continue draining while the next header is consumed.
- pkt_cnt increments on every m_tvalid & m_tready & m_tlast.
- Reset mid-packet: state→HEAD and buffer flushed. Residual payload left in the FIFO is then parsed as headers, so the system resets the FIFO together with this block.

Optional Feature:
- Macro: FIFO_KU_STREAM_READER_MAGIC_CHK_EN.
- Defined: in HEAD, a header whose tag field ≠ MAGIC is popped and discarded, err_hdr pulses for 1 cycle, and state stays HEAD. The length field is ignored.
- Undefined: tag bits are ignored and err_hdr is constant 0.

Decomposition:
- Shared package fifo_ku_stream_pkg: enum stream_rd_state_e {HEAD, DATA}; localparam constants HDR_LEN_LSB=0 and HDR_TAG_LSB=LEN_BITS; default MAGIC constant.
- Sub-module fifo_ku_skid2: the generic 2-entry valid/ready skid buffer, carrying {last, data}, with an occupancy output. It is reusable by other stream blocks.

Test Plan:
- Header len=3, then words 0x1,0x2,0x3, m_tready=1 → 3 beats on consecutive cycles; m_tlast only on 0x3; pkt_done once; pkt_cnt=1.
- Same packet with m_tready toggling 1/0 every cycle → no loss or duplication; data stable while stalled; at most 2 pops ahead of accepted beats.
- Header len=0 followed by header len=1 and word 0xAB → only 0xAB emitted, with tlast; pkt_cnt=1.
- FIFO empty for 5 cycles after 2 of 4 payload words → busy stays 1, fifo_rd_en=0 while empty; remaining 2 words emitted after refill with tlast on the 4th.
- rd_rst asserted while 1 of 4 words is buffered → next cycle m_tvalid=0 and pkt_cnt=0; a fresh header len=2 is then framed correctly.
- With the macro defined: header tag 0x1234 → err_hdr pulse, no output; next header with tag 0xA55A, len=1 → 1 beat emitted with tlast.
